// File: rtl/cve2_mac_acc_unit.sv
// Multiply-accumulate result stage: sums the multiplier product with a sampled addend,
// then holds the result for writeback. Define CVE2_MAC_SAT_EN for saturating accumulate.
module cve2_mac_acc_unit #(
    parameter int Width    = 32,
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mac_mul_en_i,
    input  logic [Width-1:0]    acc_operand_i,
    input  logic                mul_valid_i,
    input  logic [Width-1:0]    mul_result_i,
    input  logic                wb_ready_i,
    input  logic                flush_i,
    input  logic                clr_ovf_i,
    output logic [Width-1:0]    result_o,
    output logic                result_valid_o,
    output logic                busy_o,
    output logic                ovf_o,
    output logic [CntWidth-1:0] mac_cnt_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_MUL = 2'd1;
    localparam logic [1:0] ACC      = 2'd2;
    localparam logic [1:0] HOLD     = 2'd3;

    logic [1:0]          state_r;
    logic [1:0]          state_s;
    logic [Width-1:0]    acc_r;
    logic [Width-1:0]    acc_s;
    logic [Width-1:0]    prod_r;
    logic [Width-1:0]    prod_s;
    logic [Width-1:0]    sum_s;
    logic [Width-1:0]    result_s;
    logic                valid_s;
    logic                busy_s;
    logic                ovf_s;
    logic                ovf_set_s;
    logic [CntWidth-1:0] cnt_s;

    // Signed overflow: both addends share a sign that the sum does not.
    function automatic logic add_ovf(input logic [Width-1:0] a,
                                     input logic [Width-1:0] b,
                                     input logic [Width-1:0] s);
        return (a[Width-1] == b[Width-1]) && (s[Width-1] != a[Width-1]);
    endfunction

    // Next-state and next-output computation for the MAC sequence.
    always_comb begin
        sum_s     = prod_r + acc_r;
        ovf_set_s = 1'b0;
        state_s   = state_r;
        acc_s     = acc_r;
        prod_s    = prod_r;
        result_s  = result_o;
        valid_s   = result_valid_o;
        cnt_s     = mac_cnt_o;
        if (flush_i) begin
            state_s = IDLE;
            valid_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mac_mul_en_i) begin
                        acc_s   = acc_operand_i;
                        state_s = WAIT_MUL;
                    end else begin
                        state_s = IDLE;
                    end
                end
                WAIT_MUL: begin
                    if (mul_valid_i) begin
                        prod_s  = mul_result_i;
                        state_s = ACC;
                    end else begin
                        state_s = WAIT_MUL;
                    end
                end
                ACC: begin
                    ovf_set_s = add_ovf(prod_r, acc_r, sum_s);
`ifdef CVE2_MAC_SAT_EN
                    if (ovf_set_s) begin
                        // Clamp toward the sign both operands agreed on.
                        result_s = acc_r[Width-1] ? {1'b1, {(Width-1){1'b0}}}
                                                  : {1'b0, {(Width-1){1'b1}}};
                    end else begin
                        result_s = sum_s;
                    end
`else
                    result_s = sum_s;
`endif
                    valid_s = 1'b1;
                    state_s = HOLD;
                end
                HOLD: begin
                    if (wb_ready_i) begin
                        state_s = IDLE;
                        valid_s = 1'b0;
                        cnt_s   = mac_cnt_o + {{(CntWidth-1){1'b0}}, 1'b1};
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s = IDLE;
                    valid_s = 1'b0;
                end
            endcase
        end
        // A new overflow wins over a simultaneous clear.
        ovf_s  = ovf_set_s | (ovf_o & ~clr_ovf_i);
        busy_s = (state_s != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r        <= IDLE;
            acc_r          <= {Width{1'b0}};
            prod_r         <= {Width{1'b0}};
            result_o       <= {Width{1'b0}};
            result_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            ovf_o          <= 1'b0;
            mac_cnt_o      <= {CntWidth{1'b0}};
        end else begin
            state_r        <= state_s;
            acc_r          <= acc_s;
            prod_r         <= prod_s;
            result_o       <= result_s;
            result_valid_o <= valid_s;
            busy_o         <= busy_s;
            ovf_o          <= ovf_s;
            mac_cnt_o      <= cnt_s;
        end
    end

endmodule

// File: doc/cve2_mac_acc_unit.md
CVE2_MAC_ACC_UNIT -- requirements
Module: cve2_mac_acc_unit

Interface
REQ-001 Parameter Width, default 32, operand/result width in bits.
REQ-002 Parameter CntWidth, default 16, width of the completed-MAC counter.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 mac_mul_en_i  input  1  MAC multiply phase active (from MAC controller).
REQ-006 acc_operand_i  input  Width  accumulator addend (rd value), sampled at MAC start.
REQ-007 mul_valid_i  input  1  multiplier result valid this cycle.
REQ-008 mul_result_i  input  Width  multiplier low product (two's complement).
REQ-009 wb_ready_i  input  1  writeback accepts result.
REQ-010 flush_i  input  1  pipeline flush; abort any MAC in progress.
REQ-011 clr_ovf_i  input  1  clear sticky overflow flag.
REQ-012 result_o  output  Width  accumulated result.
REQ-013 result_valid_o  output  1  result_o valid; held until accepted.
REQ-014 busy_o  output  1  high in every state except IDLE.
REQ-015 ovf_o  output  1  sticky signed-overflow flag.
REQ-016 mac_cnt_o  output  CntWidth  count of MACs accepted by writeback.

Function
REQ-017 FSM states IDLE, WAIT_MUL, ACC, HOLD; all outputs registered.
REQ-018 IDLE: mac_mul_en_i=1 -> latch acc_operand_i into acc_q, next WAIT_MUL; else stay.
REQ-019 WAIT_MUL: mul_valid_i=1 -> latch mul_result_i into prod_q, next ACC; else stay, no timeout.
REQ-020 ACC: register sum of prod_q and acc_q into result_o, assert result_valid_o, next HOLD; exactly one cycle.
REQ-021 HOLD: result_o and result_valid_o stable until wb_ready_i=1; handshake cycle -> next IDLE, result_valid_o low next cycle, mac_cnt_o +1.
REQ-022 Latency: mul_valid_i accepted cycle N -> result_valid_o high from cycle N+2.
REQ-023 mac_mul_en_i outside IDLE ignored; acc_q not re-sampled.
REQ-024 mul_valid_i outside WAIT_MUL ignored.
REQ-025 Signed overflow: operands same sign, sum sign differs; sets ovf_o in ACC cycle.
REQ-026 ovf_o stays set until clr_ovf_i=1; clr_ovf_i with new overflow same cycle -> ovf_o stays 1 (set wins).
REQ-027 flush_i=1 in any state -> next IDLE, result_valid_o low next cycle, mac_cnt_o unchanged, ovf_o unchanged.
REQ-028 flush_i with wb_ready_i in HOLD -> flush wins, result dropped, counter not incremented.
REQ-029 flush_i in ACC -> no ovf_o update.
REQ-030 mac_cnt_o wraps from 2^CntWidth-1 to 0 without flag.
REQ-031 wb_ready_i while result_valid_o low has no effect.

Reset
REQ-032 rst_i high -> immediately IDLE; result_o=0, result_valid_o=0, busy_o=0, ovf_o=0, mac_cnt_o=0, acc_q=0, prod_q=0.
REQ-033 Reset mid-operation discards in-flight MAC; first MAC after release behaves as from power-up.

Configuration
REQ-034 Macro CVE2_MAC_SAT_EN selects saturating accumulate.
REQ-035 Defined: on signed overflow result_o clamps to 2^(Width-1)-1 (positive) or -2^(Width-1) (negative); ovf_o still set.
REQ-036 Undefined: result_o is sum modulo 2^Width; ovf_o still set; no clamp logic present.

Verification
REQ-037 acc=10, mul_result=6 valid 3 cycles after start, wb_ready=1 -> result_o=16, valid at N+2 for 1 cycle, mac_cnt_o=1.
REQ-038 acc=0x7FFFFFFF, mul=1 -> wrap build: result_o=0x80000000, ovf_o=1; SAT build: result_o=0x7FFFFFFF, ovf_o=1; clr_ovf_i -> ovf_o=0.
REQ-039 acc=5, mul=-3, wb_ready low 4 cycles -> result_o=2 held stable 4 cycles, accepted on 5th, busy_o low next cycle.
REQ-040 flush_i in WAIT_MUL then mul_valid_i=1 -> no result_valid_o, state IDLE, mac_cnt_o unchanged.
REQ-041 rst_i pulsed in HOLD -> all outputs 0 asynchronously; next MAC acc=1, mul=2 -> result_o=3.
REQ-042 CntWidth=4, 16 back-to-back MACs -> mac_cnt_o returns to 0; flush+wb_ready same cycle -> count not incremented.
